// File: rtl/wavegen_pkg.sv
// Shared types and default parameters for the wavetable NCO.
package wavegen_pkg;

    typedef enum logic [1:0] {
        MODE_TABLE    = 2'd0,
        MODE_SAW      = 2'd1,
        MODE_SQUARE   = 2'd2,
        MODE_TRIANGLE = 2'd3
    } wave_mode_t;

    localparam int unsigned DEF_DATA_W     = 8;
    localparam int unsigned DEF_ADDR_W     = 8;
    localparam int unsigned DEF_PHASE_W    = 24;
    localparam int unsigned DEF_STROBE_DIV = 521;

endpackage

// File: rtl/wavegen_strobe.sv
// Free-running divider: ce_o is high for one cycle out of every DIV.
module wavegen_strobe #(
    parameter int unsigned DIV = 521
) (
    input  logic clk,
    input  logic rst,
    output logic ce_o
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        ce_o  = (cnt_q == CNT_W'(DIV - 1));
        cnt_d = ce_o ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wavegen_nco.sv
// Strobed phase accumulator driving a table lookup and analytic waveforms,
// with a two-stage output pipeline shared by every mode.
module wavegen_nco
    import wavegen_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned PHASE_W    = DEF_PHASE_W,
    parameter int unsigned STROBE_DIV = DEF_STROBE_DIV
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en_i,
    input  logic               tbl_we_i,
    input  logic [ADDR_W-1:0]  tbl_addr_i,
    input  logic [DATA_W-1:0]  tbl_data_i,
    input  logic [PHASE_W-1:0] ftw_i,
    input  logic               ftw_we_i,
    input  logic [1:0]         mode_i,
    input  logic               phase_clr_i,
    output logic [DATA_W-1:0]  data_o,
    output logic               valid_o,
    output logic               wrap_o
);

    localparam int unsigned TBL_DEPTH = 2 ** ADDR_W;

    logic ce;

    wavegen_strobe #(.DIV(STROBE_DIV)) u_strobe (
        .clk  (clk),
        .rst  (rst),
        .ce_o (ce)
    );

    logic [PHASE_W-1:0] shadow_q, shadow_d;
    logic [PHASE_W-1:0] active_q, active_d;
    logic [PHASE_W-1:0] phase_q,  phase_d;
    logic [PHASE_W:0]   phase_sum;
    logic               wrap_q,   wrap_d;
    logic               s0_vld_q, s0_vld_d;
    logic               s1_vld_q, s1_vld_d;
    logic [DATA_W-1:0]  s1_p_q,   s1_p_d;
    logic               s1_msb_q, s1_msb_d;
    wave_mode_t         s1_mode_q, s1_mode_d;
    logic [DATA_W-1:0]  data_q,   data_d;
    logic               valid_q,  valid_d;
    logic [DATA_W-1:0]  tri_val;
    logic [ADDR_W-1:0]  rd_addr;

    logic [DATA_W-1:0]  tbl_mem [TBL_DEPTH];
    logic [DATA_W-1:0]  tbl_rd_q;

    assign rd_addr = phase_q[PHASE_W-1 -: ADDR_W];

    // Read-first simple dual-port table; contents survive reset.
    always_ff @(posedge clk) begin
        if (tbl_we_i) begin
            tbl_mem[tbl_addr_i] <= tbl_data_i;
        end
        tbl_rd_q <= tbl_mem[rd_addr];
    end

    always_comb begin
        shadow_d  = ftw_we_i ? ftw_i : shadow_q;
        // A retune landing on a strobe takes effect for that very step.
        active_d  = ce ? shadow_d : active_q;
        phase_sum = {1'b0, phase_q} + {1'b0, active_d};
        phase_d   = phase_q;
        wrap_d    = 1'b0;
        if (phase_clr_i) begin
            phase_d = '0;
        end else if (ce && en_i) begin
            phase_d = phase_sum[PHASE_W-1:0];
            wrap_d  = phase_sum[PHASE_W];
        end

        s0_vld_d  = ce & en_i;
        s1_vld_d  = s0_vld_q;
        s1_p_d    = s1_p_q;
        s1_msb_d  = s1_msb_q;
        s1_mode_d = s1_mode_q;
        if (s0_vld_q) begin
            s1_p_d    = phase_q[PHASE_W-1 -: DATA_W];
            s1_msb_d  = phase_q[PHASE_W-1];
            s1_mode_d = wave_mode_t'(mode_i);
        end

        tri_val = {s1_p_q[DATA_W-2:0], 1'b0};
        if (s1_msb_q) begin
            tri_val = ~tri_val;
        end

        valid_d = s1_vld_q;
        data_d  = data_q;
        if (s1_vld_q) begin
            case (s1_mode_q)
                MODE_TABLE:    data_d = tbl_rd_q;
                MODE_SAW:      data_d = s1_p_q;
                MODE_SQUARE:   data_d = {DATA_W{s1_msb_q}};
                MODE_TRIANGLE: data_d = tri_val;
                default:       data_d = data_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q  <= '0;
            active_q  <= '0;
            phase_q   <= '0;
            wrap_q    <= 1'b0;
            s0_vld_q  <= 1'b0;
            s1_vld_q  <= 1'b0;
            s1_p_q    <= '0;
            s1_msb_q  <= 1'b0;
            s1_mode_q <= MODE_TABLE;
            data_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            phase_q   <= phase_d;
            wrap_q    <= wrap_d;
            s0_vld_q  <= s0_vld_d;
            s1_vld_q  <= s1_vld_d;
            s1_p_q    <= s1_p_d;
            s1_msb_q  <= s1_msb_d;
            s1_mode_q <= s1_mode_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign wrap_o  = wrap_q;

endmodule

// File: doc/wavegen_nco.md
WAVEGEN_NCO -- requirements
Module: wavegen_nco

Interface
REQ-001 Parameter DATA_W, default 8: sample width, in bits.
REQ-002 Parameter ADDR_W, default 8: waveform table address width; table depth is 2**ADDR_W.
REQ-003 Parameter PHASE_W, default 24: phase accumulator width; must satisfy PHASE_W >= ADDR_W and PHASE_W >= DATA_W.
REQ-004 Parameter STROBE_DIV, default 521: clock cycles per sample strobe; must be >= 2.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 en_i  in  1  playback enable.
REQ-008 tbl_we_i  in  1  table write strobe.
REQ-009 tbl_addr_i  in  ADDR_W  table write address.
REQ-010 tbl_data_i  in  DATA_W  table write data.
REQ-011 ftw_i  in  PHASE_W  frequency tuning word.
REQ-012 ftw_we_i  in  1  load ftw_i into the shadow register.
REQ-013 mode_i  in  2  waveform select: 0 TABLE, 1 SAW, 2 SQUARE, 3 TRIANGLE.
REQ-014 phase_clr_i  in  1  synchronous phase clear.
REQ-015 data_o  out  DATA_W  registered sample.
REQ-016 valid_o  out  1  one-cycle pulse; data_o is new.
REQ-017 wrap_o  out  1  one-cycle pulse on phase accumulator overflow.

Function
REQ-018 Strobe counter SHALL count 0..STROBE_DIV-1, wrap to 0, and free-run regardless of en_i; ce is asserted combinationally when count == STROBE_DIV-1.
REQ-019 ftw_we_i SHALL load ftw_i into shadow on the same edge; shadow is copied to active FTW only on an edge where ce=1 (glitch-free retune); if ftw_we_i and ce coincide, the new ftw_i goes to active directly.
REQ-020 On an edge with ce=1 and en_i=1, phase SHALL become (phase + active FTW) mod 2**PHASE_W; carry-out pulses wrap_o for the following cycle.
REQ-021 phase_clr_i SHALL force phase to 0 on that edge, overriding a simultaneous increment; no wrap_o pulse results.
REQ-022 With en_i=0, phase SHALL hold, and no valid_o pulse results.
REQ-023 Table read address = phase[PHASE_W-1 -: ADDR_W]; the table is synchronous-read, one cycle of latency.
REQ-024 Table write SHALL be independent of playback; a simultaneous read and write to the same address SHALL return the old data (read-first).
REQ-025 Output mapping, with P = phase[PHASE_W-1 -: DATA_W]: TABLE = table data; SAW = P; SQUARE = all-ones if phase MSB=1, else 0; TRIANGLE = {P[DATA_W-2:0],1'b0} if MSB=0, else the bitwise inverse of that value.
REQ-026 Latency: ce edge E0 updates phase; E1 registers table read and P; E2 registers data_o with valid_o=1 for exactly one cycle. All modes SHALL use this same latency.
REQ-027 mode_i SHALL be sampled at E1 of each sample, so a mode change never mixes two mappings within one sample.
REQ-028 data_o SHALL hold its value between valid_o pulses.

Reset
REQ-029 While rst=1: strobe counter, phase, shadow FTW, active FTW, pipeline registers, data_o, valid_o and wrap_o SHALL all be 0.
REQ-030 Table contents are not reset; assertion of rst mid-operation SHALL discard in-flight samples, with no valid_o pulse after release until a new ce.
REQ-031 The first ce SHALL occur STROBE_DIV cycles after the first edge following rst deassertion.

Structure
REQ-032 Package wavegen_pkg SHALL hold the mode enum type (wave_mode_t) and the default parameter constants.
REQ-033 The strobe divider SHALL be a sub-module, wavegen_strobe (parameter DIV; ports clk, rst, ce_o).
REQ-034 The table SHALL be a single inferred simple-dual-port RAM with no vendor primitives.

Verification (STROBE_DIV=4, ADDR_W=8, DATA_W=8, PHASE_W=16)
REQ-035 Reset release; en_i=1; ftw=0x0100 -> valid_o every 4 cycles; SAW data_o = 1,2,3,...; first valid_o 2 cycles after the first ce.
REQ-036 Table loaded with table[i]=255-i, TABLE mode, ftw=0x0100 -> data_o = 254,253,...; a same-cycle write to the addressed entry returns the old value.
REQ-037 ftw=0xFF00 -> wrap_o pulses on the second step; phase=0xFE00; SQUARE data_o = 0xFF.
REQ-038 ftw_we_i with 0x0200 mid-interval -> the step size stays 0x0100 until the next ce, then becomes 0x0200.
REQ-039 phase_clr_i coincident with ce -> phase=0, no wrap_o, SAW data_o=0; en_i=0 -> no valid_o and data_o held.
REQ-040 rst pulsed between E0 and E2 -> all outputs 0, no stale valid_o; TRIANGLE at phase 0xC000 -> data_o = 0x7F.
